// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN frame-level stage sequencer.
package cnn_seq_pkg;

  localparam int unsigned STAGE_W  = 3;
  localparam int unsigned OWNER_W  = 3;
  localparam int unsigned FRAMES_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONV,
    S_RELU,
    S_POOL,
    S_FLAT,
    S_DENSE,
    S_ARGMAX,
    S_TX_WAIT,
    S_TX,
    S_ERR
  } seq_state_e;

  localparam logic [STAGE_W-1:0] STG_CONV   = 3'd0;
  localparam logic [STAGE_W-1:0] STG_RELU   = 3'd1;
  localparam logic [STAGE_W-1:0] STG_POOL   = 3'd2;
  localparam logic [STAGE_W-1:0] STG_FLAT   = 3'd3;
  localparam logic [STAGE_W-1:0] STG_DENSE  = 3'd4;
  localparam logic [STAGE_W-1:0] STG_ARGMAX = 3'd5;
  localparam logic [STAGE_W-1:0] STG_TX     = 3'd6;

  localparam int unsigned OWN_CONV = 0;
  localparam int unsigned OWN_RELU = 1;
  localparam int unsigned OWN_POOL = 2;

  function automatic logic [OWNER_W-1:0] owner_onehot(input int unsigned idx);
    return OWNER_W'(1) << idx;
  endfunction

  // TX_WAIT reports the TX code; idle/error states never time out.
  function automatic logic [STAGE_W-1:0] stage_of(input seq_state_e s);
    logic [STAGE_W-1:0] code;
    code = STG_CONV;
    case (s)
      S_RELU:          code = STG_RELU;
      S_POOL:          code = STG_POOL;
      S_FLAT:          code = STG_FLAT;
      S_DENSE:         code = STG_DENSE;
      S_ARGMAX:        code = STG_ARGMAX;
      S_TX_WAIT, S_TX: code = STG_TX;
      default:         code = STG_CONV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog; expired flags the last permitted cycle of a stage.
module stage_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1_048_576
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The restart cycle itself counts as cycle 0, so the register reloads with 1.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= CW'(1);
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = !restart && (cnt == LAST);

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Frame sequencer: walks each loaded frame through the CNN stages with
// one-frame queueing, per-stage watchdog, buffer ownership and latency stats.
module cnn_stage_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_048_576,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_loaded,
  input  logic                conv_done,
  input  logic                relu_done,
  input  logic                pool_done,
  input  logic                flat_done,
  input  logic                dense_done,
  input  logic                argmax_done,
  input  logic                tx_busy,
  input  logic                clear_err,
  output logic                conv_start,
  output logic                relu_start,
  output logic                pool_start,
  output logic                flat_start,
  output logic                dense_start,
  output logic                argmax_start,
  output logic                tx_start,
  output logic [OWNER_W-1:0]  owner,
  output logic                busy,
  output logic                pending,
  output logic                err_timeout,
  output logic                err_overrun,
  output logic [STAGE_W-1:0]  err_stage,
  output logic [CNT_W-1:0]    last_frame_cycles,
  output logic [FRAMES_W-1:0] frames_done
);

  localparam logic [CNT_W-1:0] LAT_MAX = '1;

  seq_state_e       state;
  logic             entry;
  logic             tx_seen;
  logic             expired;
  logic             exit_c;
  logic             in_flight;
  logic [CNT_W-1:0] lat_cnt;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .restart(entry),
    .expired(expired)
  );

  assign in_flight = (state != S_IDLE) && (state != S_ERR);

  // Condition that lets the current state advance this cycle.
  always_comb begin
    exit_c = 1'b0;
    case (state)
      S_IDLE:    exit_c = frame_loaded;
      S_CONV:    exit_c = conv_done;
      S_RELU:    exit_c = relu_done;
      S_POOL:    exit_c = pool_done;
      S_FLAT:    exit_c = flat_done;
      S_DENSE:   exit_c = dense_done;
      S_ARGMAX:  exit_c = argmax_done;
      S_TX_WAIT: exit_c = !tx_busy;
      S_TX:      exit_c = tx_seen && !tx_busy;
      S_ERR:     exit_c = clear_err;
      default:   exit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      entry             <= 1'b0;
      tx_seen           <= 1'b0;
      lat_cnt           <= '0;
      conv_start        <= 1'b0;
      relu_start        <= 1'b0;
      pool_start        <= 1'b0;
      flat_start        <= 1'b0;
      dense_start       <= 1'b0;
      argmax_start      <= 1'b0;
      tx_start          <= 1'b0;
      owner             <= '0;
      busy              <= 1'b0;
      pending           <= 1'b0;
      err_timeout       <= 1'b0;
      err_overrun       <= 1'b0;
      err_stage         <= '0;
      last_frame_cycles <= '0;
      frames_done       <= '0;
    end else begin
      {conv_start, relu_start, pool_start, flat_start,
       dense_start, argmax_start, tx_start} <= '0;
      entry <= 1'b0;
      if (lat_cnt != LAT_MAX) lat_cnt <= lat_cnt + CNT_W'(1);
      if (clear_err) err_overrun <= 1'b0;

      // One frame may wait behind the one in flight; a second is dropped.
      if (in_flight && frame_loaded) begin
        if (pending) err_overrun <= 1'b1;
        else         pending     <= 1'b1;
      end

      if (in_flight && expired && !exit_c) begin
        state       <= S_ERR;
        entry       <= 1'b1;
        owner       <= '0;
        busy        <= 1'b0;
        pending     <= 1'b0;
        err_timeout <= 1'b1;
        err_stage   <= stage_of(state);
      end else if (exit_c) begin
        entry <= 1'b1;
        case (state)
          S_IDLE: begin
            state      <= S_CONV;
            conv_start <= 1'b1;
            owner      <= owner_onehot(OWN_CONV);
            busy       <= 1'b1;
            lat_cnt    <= CNT_W'(1);
          end
          S_CONV: begin
            state      <= S_RELU;
            relu_start <= 1'b1;
            owner      <= owner_onehot(OWN_RELU);
          end
          S_RELU: begin
            state      <= S_POOL;
            pool_start <= 1'b1;
            owner      <= owner_onehot(OWN_POOL);
          end
          S_POOL: begin
            state      <= S_FLAT;
            flat_start <= 1'b1;
            owner      <= '0;
          end
          S_FLAT: begin
            state       <= S_DENSE;
            dense_start <= 1'b1;
          end
          S_DENSE: begin
            state        <= S_ARGMAX;
            argmax_start <= 1'b1;
          end
          S_ARGMAX: state <= S_TX_WAIT;
          S_TX_WAIT: begin
            state    <= S_TX;
            tx_start <= 1'b1;
            tx_seen  <= 1'b0;
          end
          S_TX: begin
            last_frame_cycles <= lat_cnt;
            frames_done       <= frames_done + FRAMES_W'(1);
            pending           <= 1'b0;
            // A queued frame, or one landing right now, starts with no gap.
            if (pending || frame_loaded) begin
              state      <= S_CONV;
              conv_start <= 1'b1;
              owner      <= owner_onehot(OWN_CONV);
              lat_cnt    <= CNT_W'(1);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_ERR: begin
            state       <= S_IDLE;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_stage   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_TX && tx_busy) begin
        tx_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Randomized self-checking bench for cnn_stage_sequencer against a cycle-level frame model.
module tb_cnn_stage_sequencer;

  localparam int unsigned TO = 64;
  localparam int unsigned CW = 32;

  logic        clk = 1'b0;
  logic        reset, frame_loaded, tx_busy, clear_err;
  logic [5:0]  dn;
  logic        conv_start, relu_start, pool_start, flat_start;
  logic        dense_start, argmax_start, tx_start;
  logic [2:0]  owner;
  logic        busy, pending, err_timeout, err_overrun;
  logic [2:0]  err_stage;
  logic [CW-1:0] last_frame_cycles;
  logic [15:0] frames_done;
  logic [6:0]  st;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_frames = 0;
  bit exp_pending = 1'b0;
  bit exp_overrun = 1'b0;
  bit onehot_bad = 1'b0;

  assign st = {tx_start, argmax_start, dense_start, flat_start, pool_start, relu_start, conv_start};

  cnn_stage_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .frame_loaded(frame_loaded),
    .conv_done(dn[0]), .relu_done(dn[1]), .pool_done(dn[2]), .flat_done(dn[3]),
    .dense_done(dn[4]), .argmax_done(dn[5]), .tx_busy(tx_busy), .clear_err(clear_err),
    .conv_start(conv_start), .relu_start(relu_start), .pool_start(pool_start),
    .flat_start(flat_start), .dense_start(dense_start), .argmax_start(argmax_start),
    .tx_start(tx_start), .owner(owner), .busy(busy), .pending(pending),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_stage(err_stage),
    .last_frame_cycles(last_frame_cycles), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert ($onehot0(owner) && $onehot0(st)) else begin
        onehot_bad <= 1'b1;
        $display("FAIL onehot: owner=%b starts=%b at cycle %0d", owner, st, cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Current slot must be a conv_start slot; drives dones and tx_busy for one frame.
  task automatic run_pipeline(input int fixed_d, input int inj_stage, input int inj_cnt,
                              input bit stray, output bit chained);
    int conv_slot, d, w, b, comp;
    logic [2:0] exp_own;
    logic [6:0] exp_st;
    conv_slot = cyc;
    for (int k = 0; k < 6; k++) begin
      exp_own = (k < 3) ? 3'(1 << k) : 3'b000;
      exp_st  = 7'(1 << k);
      checks++;
      if (st !== exp_st || owner !== exp_own) begin
        failures++;
        $display("FAIL stage%0d_start: starts=%b owner=%b, expected starts=%b owner=%b", k, st, owner, exp_st, exp_own);
      end
      d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
      if (k == inj_stage && d < 2 * inj_cnt) d = 2 * inj_cnt;
      if (stray && k == 0 && d < 2) d = 2;
      if (stray && k == 1) d = 0;
      for (int j = 0; j < d; j++) begin
        if (k == inj_stage && (j % 2) == 0 && (j / 2) < inj_cnt) begin
          frame_loaded = 1'b1;
          if (exp_pending) exp_overrun = 1'b1;
          else             exp_pending = 1'b1;
        end
        if (stray && k == 0 && j == 0) dn[4] = 1'b1;
        tick;
        frame_loaded = 1'b0;
        dn = '0;
        checks++;
        if (st !== 7'd0 || owner !== exp_own || pending !== exp_pending ||
            err_overrun !== exp_overrun || busy !== 1'b1) begin
          failures++;
          $display("FAIL stage%0d_hold: starts=%b owner=%b pending=%b overrun=%b busy=%b, expected 0 %b %b %b 1",
                   k, st, owner, pending, err_overrun, busy, exp_own, exp_pending, exp_overrun);
        end
      end
      dn[k] = 1'b1;
      tick;
      dn = '0;
    end
    w = (fixed_d >= 0) ? 0 : int'($urandom_range(0, 3));
    for (int j = 0; j < w; j++) begin
      tx_busy = 1'b1;
      tick;
      checks++;
      if (st !== 7'd0 || owner !== 3'd0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL tx_wait: starts=%b owner=%b busy=%b, expected 0 0 1", st, owner, busy);
      end
    end
    tx_busy = 1'b0;
    tick;
    checks++;
    if (st !== 7'b1000000 || owner !== 3'd0) begin
      failures++;
      $display("FAIL tx_start: starts=%b owner=%b, expected 1000000 000", st, owner);
    end
    b = (fixed_d >= 0) ? 20 : int'($urandom_range(1, 20));
    for (int j = 0; j < b; j++) begin
      tx_busy = 1'b1;
      tick;
      checks++;
      if (st !== 7'd0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL tx_shift: starts=%b busy=%b, expected 0 1", st, busy);
      end
    end
    tx_busy = 1'b0;
    comp = cyc;
    chained = exp_pending;
    tick;
    exp_frames++;
    exp_pending = 1'b0;
    checks++;
    if (frames_done !== 16'(exp_frames) || last_frame_cycles !== CW'(comp - conv_slot + 1)) begin
      failures++;
      $display("FAIL frame_stats: frames_done=%0d latency=%0d, expected %0d %0d",
               frames_done, last_frame_cycles, exp_frames, comp - conv_slot + 1);
    end
    checks++;
    if (conv_start !== chained || busy !== chained || pending !== 1'b0) begin
      failures++;
      $display("FAIL frame_end: conv_start=%b busy=%b pending=%b, expected %b %b 0",
               conv_start, busy, pending, chained, chained);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    frame_loaded = 1'b1;
    tick;
    tick;
    checks++;
    if (st !== 7'd0 || owner !== 3'd0 || busy !== 1'b0 || pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: starts=%b owner=%b busy=%b pending=%b, expected all 0", st, owner, busy, pending);
    end
    checks++;
    if (err_timeout !== 1'b0 || err_overrun !== 1'b0 || err_stage !== 3'd0) begin
      failures++;
      $display("FAIL reset_err: timeout=%b overrun=%b stage=%0d, expected 0 0 0", err_timeout, err_overrun, err_stage);
    end
    checks++;
    if (last_frame_cycles !== '0 || frames_done !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats: latency=%0d frames=%0d, expected 0 0", last_frame_cycles, frames_done);
    end
    frame_loaded = 1'b0;
    reset = 1'b0;
    cyc = 0;
    tick;
    checks++;
    if (st !== 7'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: starts=%b busy=%b, expected 0 0", st, busy);
    end
  endtask

  task automatic test_full_frame;
    bit ch;
    while (cyc < 10) tick;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(5, -1, 0, 1'b0, ch);
    checks++;
    if (last_frame_cycles !== CW'(58) || frames_done !== 16'd1) begin
      failures++;
      $display("FAIL full_frame: latency=%0d frames=%0d, expected 58 1", last_frame_cycles, frames_done);
    end
  endtask

  task automatic test_queued;
    bit ch;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(-1, 2, 1, 1'b0, ch);
    if (ch) run_pipeline(-1, -1, 0, 1'b0, ch);
  endtask

  task automatic test_overrun;
    bit ch;
    int base;
    base = exp_frames;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(-1, 4, 3, 1'b0, ch);
    if (ch) run_pipeline(-1, -1, 0, 1'b0, ch);
    for (int j = 0; j < 5; j++) tick;
    checks++;
    if (frames_done !== 16'(base + 2) || err_overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun: frames=%0d overrun=%b busy=%b, expected %0d 1 0", frames_done, err_overrun, busy, base + 2);
    end
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    exp_overrun = 1'b0;
    checks++;
    if (err_overrun !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: overrun=%b timeout=%b busy=%b, expected 0 0 0", err_overrun, err_timeout, busy);
    end
  endtask

  task automatic test_stray_dones;
    bit ch;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(-1, -1, 0, 1'b1, ch);
    checks++;
    if (onehot_bad !== 1'b0) begin
      failures++;
      $display("FAIL stray_onehot: flag=%b, expected 0", onehot_bad);
    end
  endtask

  task automatic test_random;
    bit ch;
    int inj, cnt;
    for (int i = 0; i < 6; i++) begin
      inj = int'($urandom_range(0, 7));
      if (inj >= 6) inj = -1;
      cnt = int'($urandom_range(1, 2));
      frame_loaded = 1'b1;
      tick;
      frame_loaded = 1'b0;
      run_pipeline(-1, inj, cnt, 1'b0, ch);
      if (ch) run_pipeline(-1, -1, 0, 1'b0, ch);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick;
    end
  endtask

  task automatic test_timeout;
    bit ch;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    dn[0] = 1'b1;
    tick;
    dn = '0;
    checks++;
    if (relu_start !== 1'b1 || owner !== 3'b010) begin
      failures++;
      $display("FAIL timeout_relu_start: relu_start=%b owner=%b, expected 1 010", relu_start, owner);
    end
    for (int j = 0; j < int'(TO) - 1; j++) begin
      frame_loaded = (j == 3);
      tick;
      frame_loaded = 1'b0;
      checks++;
      if (err_timeout !== 1'b0 || owner !== 3'b010 || pending !== (j >= 3)) begin
        failures++;
        $display("FAIL timeout_hold: cycle=%0d timeout=%b owner=%b pending=%b, expected 0 010 %b",
                 j, err_timeout, owner, pending, j >= 3);
      end
    end
    tick;
    checks++;
    if (err_timeout !== 1'b1 || err_stage !== 3'd1 || owner !== 3'd0 ||
        busy !== 1'b0 || pending !== 1'b0 || st !== 7'd0) begin
      failures++;
      $display("FAIL timeout_err: timeout=%b stage=%0d owner=%b busy=%b pending=%b starts=%b, expected 1 1 000 0 0 0",
               err_timeout, err_stage, owner, busy, pending, st);
    end
    exp_pending = 1'b0;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    tick;
    checks++;
    if (st !== 7'd0 || err_timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_ignores_frame: starts=%b timeout=%b busy=%b, expected 0 1 0", st, err_timeout, busy);
    end
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    exp_overrun = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || err_overrun !== 1'b0 || err_stage !== 3'd0 || busy !== 1'b0 || st !== 7'd0) begin
      failures++;
      $display("FAIL err_clear: timeout=%b overrun=%b stage=%0d busy=%b starts=%b, expected 0 0 0 0 0",
               err_timeout, err_overrun, err_stage, busy, st);
    end
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(-1, -1, 0, 1'b0, ch);
  endtask

  task automatic test_mid_reset;
    bit ch;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dn[k] = 1'b1;
      frame_loaded = (k == 0);
      tick;
      dn = '0;
      frame_loaded = 1'b0;
    end
    checks++;
    if (argmax_start !== 1'b1 || pending !== 1'b1) begin
      failures++;
      $display("FAIL mid_argmax: argmax_start=%b pending=%b, expected 1 1", argmax_start, pending);
    end
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (st !== 7'd0 || owner !== 3'd0 || busy !== 1'b0 || pending !== 1'b0 ||
        err_timeout !== 1'b0 || err_overrun !== 1'b0 || err_stage !== 3'd0 ||
        frames_done !== 16'd0 || last_frame_cycles !== '0) begin
      failures++;
      $display("FAIL mid_reset: starts=%b owner=%b busy=%b pending=%b errs=%b%b stage=%0d frames=%0d lat=%0d, expected all 0",
               st, owner, busy, pending, err_timeout, err_overrun, err_stage, frames_done, last_frame_cycles);
    end
    dn[5] = 1'b1;
    tick;
    dn = '0;
    checks++;
    if (st !== 7'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: starts=%b busy=%b, expected 0 0", st, busy);
    end
    exp_frames = 0;
    exp_pending = 1'b0;
    exp_overrun = 1'b0;
    frame_loaded = 1'b1;
    tick;
    frame_loaded = 1'b0;
    run_pipeline(-1, -1, 0, 1'b0, ch);
  endtask

  initial begin
    reset = 1'b1;
    frame_loaded = 1'b0;
    tx_busy = 1'b0;
    clear_err = 1'b0;
    dn = '0;
    tick;
    test_reset;
    test_full_frame;
    test_queued;
    test_overrun;
    test_stray_dones;
    test_random;
    test_timeout;
    test_mid_reset;
    tick;
    checks++;
    if (onehot_bad !== 1'b0) begin
      failures++;
      $display("FAIL final_onehot: flag=%b, expected 0", onehot_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
